// File: rtl/i2c_lut_config_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_lut_config_sequencer                                      |
// | Description : Walks a sensor register LUT and issues one I2C write per      |
// |               entry through a req/done handshake. It waits a settle delay   |
// |               after power-up and after a soft-reset write, retries NACKed   |
// |               writes, and reports a done or error level.                    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module i2c_lut_config_sequencer #(
  parameter logic [15:0] PWRUP_DELAY = 16'd50000,
  parameter logic [15:0] SWRST_DELAY = 16'd20000,
  parameter int          MAX_RETRY   = 3,
  parameter int          IDX_W       = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [IDX_W-1:0] lut_index_o,
  input  logic [23:0]      lut_data_i,
  input  logic [IDX_W-1:0] lut_size_i,
  output logic             i2c_req_o,
  output logic [15:0]      i2c_reg_addr_o,
  output logic [7:0]       i2c_wdata_o,
  input  logic             i2c_done_i,
  input  logic             i2c_nack_i,
  output logic             busy_o,
  output logic             config_done_o,
  output logic             config_err_o,
  output logic [IDX_W-1:0] err_index_o
);

  // Retry counter must hold 0..MAX_RETRY; keep it at least one bit wide.
  localparam int                 RETRY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);
  localparam logic [15:0]        SWRST_ADDR = 16'h0103;
  // Terminal counts; a programmed delay of 0 still costs one cycle.
  localparam logic [15:0]        PWR_LAST   = (PWRUP_DELAY == 16'd0) ? 16'd0 : PWRUP_DELAY - 16'd1;
  localparam logic [15:0]        SWRST_LAST = (SWRST_DELAY == 16'd0) ? 16'd0 : SWRST_DELAY - 16'd1;
  localparam logic [IDX_W-1:0]   IDX_ZERO   = '0;
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);

  typedef enum logic [2:0] {
    S_PWR_WAIT  = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_XFER = 3'd3,
    S_DELAY     = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6,
    S_ERR       = 3'd7
  } state_e;

  state_e             state_q,   state_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;
  logic [15:0]        addr_q,    addr_d;
  logic [7:0]         wdata_q,   wdata_d;
  logic               req_q,     req_d;
  logic [15:0]        dly_q,     dly_d;
  logic [RETRY_W-1:0] retry_q,   retry_d;

  logic [IDX_W-1:0]   last_idx;
  logic               table_empty;

  assign last_idx    = lut_size_i - IDX_ONE;
  assign table_empty = (lut_size_i == IDX_ZERO);

  // State and datapath registers; reset aborts any transfer at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PWR_WAIT;
      idx_q     <= '0;
      err_idx_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_q     <= 1'b0;
      dly_q     <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      req_q     <= req_d;
      dly_q     <= dly_d;
      retry_q   <= retry_d;
    end
  end

  // Next-state logic. req_d is the request level for the next cycle, so the
  // request is a clean register output that rises on entry to ISSUE and
  // falls the cycle after done is sampled.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    req_d     = 1'b0;
    dly_d     = '0;
    retry_d   = retry_q;

    case (state_q)
      S_PWR_WAIT: begin
        if (dly_q == PWR_LAST) begin
          state_d = table_empty ? S_DONE : S_FETCH;
        end else begin
          dly_d = dly_q + 16'd1;
        end
      end

      // Only first attempts pass through here, so the retry count restarts.
      S_FETCH: begin
        addr_d  = lut_data_i[23:8];
        wdata_d = lut_data_i[7:0];
        retry_d = '0;
        req_d   = 1'b1;
        state_d = S_ISSUE;
      end

      // After a NACK the request is low here, giving the one-cycle gap.
      S_ISSUE: begin
        req_d   = 1'b1;
        state_d = S_WAIT_XFER;
      end

      S_WAIT_XFER: begin
        req_d = 1'b1;
        if (i2c_done_i) begin
          req_d = 1'b0;
          if (!i2c_nack_i) begin
            state_d = (addr_q == SWRST_ADDR) ? S_DELAY : S_NEXT;
          end else if (retry_q == RETRY_MAX) begin
            err_idx_d = idx_q;
            state_d   = S_ERR;
          end else begin
            retry_d = retry_q + RETRY_ONE;
            state_d = S_ISSUE;
          end
        end
      end

      // Sensor soft reset settle time.
      S_DELAY: begin
        if (dly_q == SWRST_LAST) begin
          state_d = S_NEXT;
        end else begin
          dly_d = dly_q + 16'd1;
        end
      end

      S_NEXT: begin
        if (idx_q == last_idx) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_FETCH;
        end
      end

      // Rerun from index 0 without the power-up wait; an empty table
      // completes immediately instead of walking garbage entries.
      S_DONE, S_ERR: begin
        if (start_i) begin
          idx_d   = '0;
          state_d = table_empty ? S_DONE : S_FETCH;
        end
      end

      default: begin
        state_d = S_PWR_WAIT;
      end
    endcase
  end

  assign lut_index_o    = idx_q;
  assign i2c_req_o      = req_q;
  assign i2c_reg_addr_o = addr_q;
  assign i2c_wdata_o    = wdata_q;
  assign err_index_o    = err_idx_q;
  assign config_done_o  = (state_q == S_DONE);
  assign config_err_o   = (state_q == S_ERR);
  assign busy_o         = (state_q != S_DONE) && (state_q != S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_i2c_lut_config_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_i2c_lut_config_sequencer                                   |
// | Description : Directed self-checking bench with a simple I2C master model.  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_i2c_lut_config_sequencer;

  localparam int IDX_W   = 9;
  localparam int PWR     = 10;
  localparam int SWR     = 20;
  localparam int ACK_LAT = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [IDX_W-1:0] lut_index_o;
  logic [23:0]      lut_data_i;
  logic [IDX_W-1:0] lut_size_i = 9'd4;
  logic             i2c_req_o;
  logic [15:0]      i2c_reg_addr_o;
  logic [7:0]       i2c_wdata_o;
  logic             i2c_done_i;
  logic             i2c_nack_i;
  logic             busy_o;
  logic             config_done_o;
  logic             config_err_o;
  logic [IDX_W-1:0] err_index_o;

  logic [23:0] lut [0:3];

  i2c_lut_config_sequencer #(
    .PWRUP_DELAY (16'd10),
    .SWRST_DELAY (16'd20),
    .MAX_RETRY   (3),
    .IDX_W       (IDX_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .lut_index_o    (lut_index_o),
    .lut_data_i     (lut_data_i),
    .lut_size_i     (lut_size_i),
    .i2c_req_o      (i2c_req_o),
    .i2c_reg_addr_o (i2c_reg_addr_o),
    .i2c_wdata_o    (i2c_wdata_o),
    .i2c_done_i     (i2c_done_i),
    .i2c_nack_i     (i2c_nack_i),
    .busy_o         (busy_o),
    .config_done_o  (config_done_o),
    .config_err_o   (config_err_o),
    .err_index_o    (err_index_o)
  );

  always #5 clk = ~clk;

  // Combinational LUT
  always_comb begin
    lut_data_i = 24'h0;
    if (lut_index_o < 4) lut_data_i = lut[lut_index_o[1:0]];
  end

  // Posedge counter
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Request-rise monitor: logs every new request with its entry and cycle
  int          rise_cnt = 0;
  logic [23:0] rise_ent [0:63];
  int          rise_cyc [0:63];
  logic        req_prev = 1'b0;
  always @(negedge clk) begin
    if (i2c_req_o && !req_prev && rise_cnt < 64) begin
      rise_ent[rise_cnt] <= {i2c_reg_addr_o, i2c_wdata_o};
      rise_cyc[rise_cnt] <= cyc;
      rise_cnt           <= rise_cnt + 1;
    end
    req_prev <= i2c_req_o;
  end

  // I2C master model: done pulse ACK_LAT cycles after req rises.
  // nack_limit < 0 means NACK the target address forever.
  int          nack_limit = 0;
  logic [15:0] nack_addr  = 16'h3039;
  int          test_id    = 0;
  int          swrst_done_cyc = 0;
  initial begin : master
    int   n;
    int   nack_given;
    int   seen_id;
    logic nk;
    nack_given = 0;
    seen_id    = 0;
    i2c_done_i = 1'b0;
    i2c_nack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (seen_id != test_id) begin
        seen_id    = test_id;
        nack_given = 0;
      end
      if (rst_n && i2c_req_o) begin
        n = 1;
        while (n < ACK_LAT && rst_n) begin
          @(negedge clk);
          n++;
        end
        if (rst_n) begin
          nk = (i2c_reg_addr_o == nack_addr) && ((nack_limit < 0) || (nack_given < nack_limit));
          if (nk) nack_given++;
          i2c_done_i = 1'b1;
          i2c_nack_i = nk;
          if (!nk && i2c_reg_addr_o == 16'h0103) swrst_done_cyc = cyc + 1;
          @(negedge clk);
          i2c_done_i = 1'b0;
          i2c_nack_i = 1'b0;
        end
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_end(input string tag, input int limit);
    int k;
    k = 0;
    while (!(config_done_o || config_err_o) && k < limit) begin
      tick(1);
      k++;
    end
    check({tag, "_timeout"}, {31'd0, config_done_o | config_err_o}, 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_idx"},     {23'd0, lut_index_o},    32'd0);
    check({tag, "_req"},     {31'd0, i2c_req_o},      32'd0);
    check({tag, "_addr"},    {16'd0, i2c_reg_addr_o}, 32'd0);
    check({tag, "_wdata"},   {24'd0, i2c_wdata_o},    32'd0);
    check({tag, "_busy"},    {31'd0, busy_o},         32'd1);
    check({tag, "_done"},    {31'd0, config_done_o},  32'd0);
    check({tag, "_err"},     {31'd0, config_err_o},   32'd0);
    check({tag, "_erridx"},  {23'd0, err_index_o},    32'd0);
  endtask

  function automatic int count_addr(input int from, input logic [15:0] a);
    int c;
    c = 0;
    for (int i = from; i < rise_cnt; i++) if (rise_ent[i][23:8] == a) c++;
    return c;
  endfunction

  initial begin : main
    int c0;
    int base;
    int k;
    lut[0] = 24'h0103_01;
    lut[1] = 24'h0100_00;
    lut[2] = 24'h3039_d3;
    lut[3] = 24'h0100_01;

    // ---- reset state and power-up timing ----
    tick(2);
    check_reset("rst");
    rst_n = 1'b1;
    c0    = cyc;
    base  = rise_cnt;
    tick(PWR);
    check("req_before_11", {31'd0, i2c_req_o}, 32'd0);
    tick(1);
    check("req_at_11", {31'd0, i2c_req_o}, 32'd1);
    check("first_req_lat", rise_cyc[base] - c0, 32'd11);
    wait_end("run1", 500);
    check("run1_writes", rise_cnt - base, 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("run1_ent%0d", i), {8'd0, rise_ent[base + i]}, {8'd0, lut[i]});
    check("swrst_gap_ge", {31'd0, (rise_cyc[base + 1] - swrst_done_cyc) >= SWR}, 32'd1);
    check("run1_done", {31'd0, config_done_o}, 32'd1);
    check("run1_busy", {31'd0, busy_o}, 32'd0);
    check("run1_err",  {31'd0, config_err_o}, 32'd0);

    // ---- rerun from DONE, NACK entry 2 twice ----
    test_id    = 1;
    nack_limit = 2;
    base       = rise_cnt;
    c0         = cyc;
    start_i    = 1'b1;
    tick(1);
    start_i    = 1'b0;
    check("rerun_busy", {31'd0, busy_o}, 32'd1);
    check("rerun_done_clr", {31'd0, config_done_o}, 32'd0);
    check("rerun_idx", {23'd0, lut_index_o}, 32'd0);
    tick(1);
    check("rerun_req", {31'd0, i2c_req_o}, 32'd1);
    check("rerun_lat", rise_cyc[base] - c0, 32'd2);
    tick(1);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    check("busy_start_idx", {23'd0, lut_index_o}, 32'd0);
    check("busy_start_req", {31'd0, i2c_req_o}, 32'd1);
    wait_end("run2", 800);
    check("run2_writes", rise_cnt - base, 32'd6);
    check("run2_3039_cnt", count_addr(base, 16'h3039), 32'd3);
    check("run2_last_ent", {8'd0, rise_ent[rise_cnt - 1]}, 32'h0001_0001);
    check("run2_done", {31'd0, config_done_o}, 32'd1);
    check("run2_err",  {31'd0, config_err_o}, 32'd0);

    // ---- NACK entry 2 forever: retries exhausted ----
    test_id    = 2;
    nack_limit = -1;
    base       = rise_cnt;
    start_i    = 1'b1;
    tick(1);
    start_i    = 1'b0;
    wait_end("run3", 800);
    check("run3_err",     {31'd0, config_err_o}, 32'd1);
    check("run3_done",    {31'd0, config_done_o}, 32'd0);
    check("run3_busy",    {31'd0, busy_o}, 32'd0);
    check("run3_erridx",  {23'd0, err_index_o}, 32'd2);
    check("run3_idx",     {23'd0, lut_index_o}, 32'd2);
    check("run3_3039_cnt", count_addr(base, 16'h3039), 32'd4);
    check("run3_writes",  rise_cnt - base, 32'd6);
    tick(40);
    check("run3_no_more", rise_cnt - base, 32'd6);
    check("run3_req_low", {31'd0, i2c_req_o}, 32'd0);

    // ---- empty table ----
    test_id    = 3;
    nack_limit = 0;
    lut_size_i = 9'd0;
    rst_n      = 1'b0;
    tick(2);
    rst_n = 1'b1;
    base  = rise_cnt;
    tick(PWR - 1);
    check("empty_not_yet", {31'd0, config_done_o}, 32'd0);
    check("empty_busy", {31'd0, busy_o}, 32'd1);
    tick(1);
    check("empty_done", {31'd0, config_done_o}, 32'd1);
    check("empty_busy_low", {31'd0, busy_o}, 32'd0);
    tick(20);
    check("empty_no_req", rise_cnt - base, 32'd0);

    // ---- async reset mid-transfer at index 3 ----
    lut_size_i = 9'd4;
    rst_n      = 1'b0;
    tick(2);
    rst_n = 1'b1;
    k = 0;
    while (!(lut_index_o == 9'd3 && i2c_req_o) && k < 400) begin
      tick(1);
      k++;
    end
    check("idx3_reached", {31'd0, k < 400}, 32'd1);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst");
    tick(2);
    rst_n = 1'b1;
    c0    = cyc;
    base  = rise_cnt;
    tick(11);
    check("rst2_req_seen", {31'd0, rise_cnt > base}, 32'd1);
    check("rst2_lat", rise_cyc[base] - c0, 32'd11);
    check("rst2_ent0", {8'd0, rise_ent[base]}, {8'd0, lut[0]});
    wait_end("run5", 500);
    check("run5_done", {31'd0, config_done_o}, 32'd1);
    check("run5_writes", rise_cnt - base, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
